// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, synchronous flush, optional two-entry skid buffer.
// The control field is zeroed in the register itself whenever the stage holds no entry.
module pipe_stage_elastic #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 320,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state;
    logic              out_valid_r;
    logic              in_ready_r;
    logic [1:0]        occ_r;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_xfer;
    logic              out_xfer;

    // With the skid buffer, in_ready is a flop and never sees out_ready combinationally.
    assign in_ready  = (SKID != 0) ? in_ready_r : (!out_valid_r || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid_r && out_ready;

    assign out_valid = out_valid_r;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = occ_r;

    // NOTE: all state here is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd0;
            main_ctrl   <= '0;
            // NOTE: datapath registers are reset too, so out_data reads zero right after reset.
            main_data   <= '0;
            skid_ctrl   <= '0;
            skid_data   <= '0;
        end else if (flush) begin
            // out_data is left alone; it is meaningless while out_valid is low.
            state       <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd0;
            main_ctrl   <= '0;
            skid_ctrl   <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_ctrl   <= in_ctrl;
                        main_data   <= in_data;
                        state       <= ST_FULL;
                        out_valid_r <= 1'b1;
                        occ_r       <= 2'd1;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (out_xfer) begin
                        main_ctrl   <= '0;
                        state       <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                        occ_r       <= 2'd0;
                    end else if (in_xfer) begin
                        // Only reachable with SKID=1: downstream stalled while in_ready was still high.
                        skid_ctrl  <= in_ctrl;
                        skid_data  <= in_data;
                        state      <= ST_SKID;
                        in_ready_r <= 1'b0;
                        occ_r      <= 2'd2;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                        skid_ctrl  <= '0;
                        state      <= ST_FULL;
                        in_ready_r <= 1'b1;
                        occ_r      <= 2'd1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    occ_r       <= 2'd0;
                    main_ctrl   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised pipeline stage register with a valid/ready handshake, synchronous flush, and an optional skid buffer.
- Replaces the fixed, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block that supports stall, flush and back-pressure.
- Payload is split into two fields:
  - control field: forced to zero whenever the stage is empty, so an empty stage is a bubble with no side effects (no regWrite, memWrite, branch, ecall).
  - data field: plain datapath values.

Parameters:
- CTRL_W, 16, width of the control field; zeroed on bubble and reset.
- DATA_W, 320, width of the data field (operands, PC, immediate, register addresses).
- SKID, 1, 0 = single register with combinational ready path; 1 = two-entry skid buffer with registered in_ready.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous kill of all held entries (branch mispredict, trap).
- in_valid  input  1  upstream has a valid entry.
- in_ready  output  1  stage accepts an entry this cycle.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream data field.
- out_valid  output  1  stage presents a valid entry.
- out_ready  input  1  downstream consumes this cycle.
- out_ctrl  output  CTRL_W  held control; all-zero when out_valid=0.
- out_data  output  DATA_W  held data.
- occupancy  output  2  entries held: 0, 1 or 2 (2 only when SKID=1).

Behaviour:
- Handshakes:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - Both are evaluated at the same rising edge.
- Reset:
  - Reset, synchronous, active-high, highest priority.
  - Next edge: occupancy=0, out_valid=0, out_ctrl=0, out_data=0, skid entry cleared.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset asserted mid-stream discards all held entries; no transfer-out is counted in that cycle.
- Flush:
  - Priority below reset, above everything else.
  - Next edge: occupancy=0, out_valid=0, out_ctrl=0.
  - Any same-cycle input transfer is discarded.
  - out_data is not cleared (don't-care under out_valid=0).
- States and transitions (SKID=1):
  - EMPTY (occ 0): in_ready=1, out_valid=0. Input transfer -> FULL, with main register loaded.
  - FULL (occ 1): in_ready=1, out_valid=1.
    - in and out -> FULL, main reloaded from input.
    - out only -> EMPTY.
    - in only (downstream stalled) -> SKID, input captured in skid register.
  - SKID (occ 2): in_ready=0, out_valid=1, main register presented. Output transfer -> FULL, with skid contents moved to main.
  - in_ready is a registered signal: it equals (next state != SKID) and has no combinational path from out_ready.
- SKID=0:
  - States EMPTY and FULL only.
  - in_ready = !out_valid || out_ready (combinational).
  - Simultaneous in and out reloads the register with zero bubble.
  - occupancy never exceeds 1.
- Latency and throughput:
  - Entry accepted at edge N is presented at out_* after edge N (1-cycle latency).
  - Sustained throughput is 1 entry/cycle when out_ready is held high.
- Bubble rule: out_ctrl = 0 whenever out_valid=0. It is implemented as registered zeroing, not output gating, so out_ctrl is glitch-free.
- Ordering: entries leave strictly in arrival order; no entry is duplicated or dropped except by flush or reset.
- in_ctrl and in_data are sampled only on an input transfer; they are don't-care otherwise.

Test Plan:
- Reset then stream (SKID=1, out_ready=1): in_data=1..8 on consecutive cycles -> out_data=1..8 one cycle later, no gaps, occupancy=1 throughout.
- Back-pressure: stream 0xA, 0xB, 0xC; drop out_ready for 3 cycles after 0xA is presented -> 0xB is held in skid, in_ready=0, occupancy=2, 0xC is stalled; on release, the output sequence is 0xA, 0xB, 0xC exactly once each.
- Flush with occupancy=2 and in_valid=1 (in_ctrl=0xFFFF) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the incoming entry is not seen.
- Reset asserted mid-stream with occupancy=1 -> next edge all outputs zero; the first entry after deassert emerges with correct data.
- SKID=0 build: out_ready toggled 1,0,1,0 with continuous in_valid -> in_ready mirrors out_ready whenever FULL; occupancy is never 2; no entry is lost.
- Bubble check: in_valid=0 for 2 cycles while out_ready=1 -> out_valid=0 and out_ctrl=0 for those cycles; out_data holds its last value.
